tx_skp_inserter: RTL and testbench
==================================

# tx_skp_inserter

Transmit-side symbol scheduler sitting directly upstream of the 8b/10b encoder. It accepts byte/K-flag symbols from the link layer through a valid/ready handshake and drives `txdata`/`txdatak` into the encoder. It periodically inserts a SKP ordered set (one COM followed by `SKP_LEN` SKP symbols) for receiver clock compensation, only at packet boundaries, and fills empty cycles with an idle symbol.

## Interface
Parameters:
- `SKP_INTERVAL`, default 1180: minimum output symbols from one COM to the next scheduling point; legal range 8..65535.
- `SKP_LEN`, default 3: number of K28.0 SKP symbols following each COM; legal range 1..5.
- `IDLE_SYM`, default 8'h00: data byte (K=0) emitted when no input is available.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `reset` input 1: synchronous, active-high reset.
- `in_data` input 8: symbol byte from the link layer.
- `in_datak` input 1: K-flag for `in_data`.
- `in_valid` input 1: input symbol present.
- `in_last` input 1: qualifies `in_data` as the final symbol of a packet.
- `in_ready` output 1: block accepts the input this cycle; combinational.
- `txdata` output 8: symbol to the encoder; registered.
- `txdatak` output 1: K-flag to the encoder; registered.
- `skp_pending` output 1: insertion due but not yet started; registered.
- `skp_sent_cnt` output 16: completed SKP sets; present only with `TX_SKP_STATS_EN`.

## Operation
- States:
  - DATA: pass-through or idle.
  - COM: emit 8'hBC, K=1.
  - SKP: emit 8'h1C, K=1, for `SKP_LEN` cycles, tracked by a skip counter.
- `sym_cnt` (16 bit, saturating at `SKP_INTERVAL-1`):
  - increments every cycle in every state;
  - clears to 0 on the edge that registers COM.
- `skp_pending` sets on the edge where `sym_cnt` reaches `SKP_INTERVAL-1`; it stays set until the COM edge.
- `in_pkt` flag:
  - set on accepting a symbol with `in_last`=0;
  - cleared on accepting a symbol with `in_last`=1.
  - A gap in `in_valid` mid-packet does not clear it.
- Go condition: state DATA && `skp_pending` && !`in_pkt`.
  - When go holds, `in_ready`=0 and the next edge registers COM and enters COM.
- `in_ready` = state DATA && !go && !reset.
- DATA state, no go:
  - `in_valid`=1: register `in_data`/`in_datak`.
  - Otherwise: register `IDLE_SYM`, K=0.
- COM goes to SKP. SKP returns to DATA after the `SKP_LEN`-th SKP symbol is registered.
- No input symbol is ever dropped or duplicated. Input is held off only by `in_ready`=0.
- Reset values:
  - `txdata`=8'h00, `txdatak`=0, `skp_pending`=0, `in_ready`=0 while `reset`=1;
  - state DATA, `sym_cnt`=0, `in_pkt`=0, `skp_sent_cnt`=0.

## Timing
- Input to output latency is 1 cycle: a symbol accepted in cycle t appears on `txdata` in cycle t+1.
- Go decided in cycle t:
  - COM on `txdata` in t+1;
  - SKP in t+2..t+1+`SKP_LEN`.
  - `in_ready` is 0 for cycles t..t+`SKP_LEN`; it may rise in t+`SKP_LEN`+1.
  - The first post-set symbol appears on `txdata` in t+`SKP_LEN`+2.
- With no traffic, COM symbols on `txdata` are exactly `SKP_INTERVAL` cycles apart.
- `in_last` accepted in cycle t while pending: go in t+1, since `in_pkt` clears at the edge.
- Pending arrives mid-packet: insertion is deferred indefinitely until the packet ends. `sym_cnt` holds saturated.
- `reset` asserted during COM or SKP aborts the set. Outputs take reset values at the next edge, and no partial set is counted.
- `in_valid` dropping while `in_ready`=0 is legal. Data must remain stable while `in_valid`=1 and `in_ready`=0.

## Configuration
- Macro: `TX_SKP_STATS_EN`.
- Defined:
  - `skp_sent_cnt` port exists;
  - it increments on the edge that registers the last SKP of a set;
  - it wraps 16'hFFFF to 16'h0000.
- Undefined: the port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset: hold `reset`=1 for 3 cycles with `in_valid`=1.
  - Required: `txdata`=00, `txdatak`=0, `in_ready`=0, `skp_pending`=0 throughout.
  - After release, the first symbol appears 1 cycle after the first `in_ready`=1.
- Idle only, `SKP_INTERVAL`=16, `SKP_LEN`=3, no `in_valid`.
  - Required: repeating pattern BC,1C,1C,1C then 12×00.
  - COM symbols are exactly 16 cycles apart.
- Deferral: 40-symbol packet (`in_last` on the 40th) starting 2 cycles before pending sets, `SKP_INTERVAL`=16.
  - Required: all 40 bytes contiguous and in order.
  - COM appears 2 cycles after the `in_last` acceptance cycle.
- Mid-packet gap: drop `in_valid` for 5 cycles inside a packet while pending.
  - Required: `IDLE_SYM` fills the gap.
  - No COM until after `in_last`.
- Back-to-back streaming, `in_valid` always 1, `in_last` every 4th symbol.
  - Required: `in_ready` low for exactly `SKP_LEN`+1 cycles per set.
  - Data order is preserved, with zero lost or duplicated symbols.
- Reset mid-set: assert `reset` on the second SKP.
  - Required: next edge `txdata`=00, `txdatak`=0.
  - With `TX_SKP_STATS_EN`, `skp_sent_cnt` is 0; the next COM comes `SKP_INTERVAL` cycles after release.

Source files
------------

// File: rtl/tx_skp_inserter.sv
// Transmit symbol scheduler ahead of the 8b/10b encoder: passes link symbols, fills idles and
// inserts COM+SKP ordered sets at packet boundaries. Define TX_SKP_STATS_EN for the skp_sent_cnt port.
module tx_skp_inserter #(
    parameter int          SKP_INTERVAL = 1180,
    parameter int          SKP_LEN      = 3,
    parameter logic [7:0]  IDLE_SYM     = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_datak,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        skp_pending
`ifdef TX_SKP_STATS_EN
    ,
    output logic [15:0] skp_sent_cnt
`endif
);

    localparam logic [15:0] SYM_MAX  = 16'(SKP_INTERVAL - 1);
    localparam logic [2:0]  SKP_LAST = 3'(SKP_LEN - 1);
    localparam logic [7:0]  K_COM    = 8'hBC;
    localparam logic [7:0]  K_SKP    = 8'h1C;

    typedef enum logic [1:0] {
        ST_DATA = 2'd0,
        ST_COM  = 2'd1,
        ST_SKP  = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] sym_cnt_r;
    logic [2:0]  skp_cnt_r;
    logic        in_pkt_r;
    logic        go_s;
    logic        accept_s;
    logic        last_skp_s;

    // Insertion decision, handshake and end-of-set detection.
    always_comb begin
        go_s     = (state_r == ST_DATA) && skp_pending && !in_pkt_r;
        in_ready = (state_r == ST_DATA) && !go_s && !reset;
        accept_s = in_valid && in_ready;
        if (state_r == ST_COM) begin
            last_skp_s = (SKP_LEN == 1);
        end else if (state_r == ST_SKP) begin
            last_skp_s = (skp_cnt_r >= SKP_LAST);
        end else begin
            last_skp_s = 1'b0;
        end
    end

    // Symbol counter, pending flag, packet tracking and output symbol selection.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_DATA;
            sym_cnt_r   <= 16'd0;
            skp_cnt_r   <= 3'd0;
            in_pkt_r    <= 1'b0;
            skp_pending <= 1'b0;
            txdata      <= 8'h00;
            txdatak     <= 1'b0;
        end else begin
            // The counter saturates so a long deferral keeps the request alive.
            if (go_s) begin
                sym_cnt_r   <= 16'd0;
                skp_pending <= 1'b0;
            end else if (sym_cnt_r != SYM_MAX) begin
                sym_cnt_r   <= sym_cnt_r + 16'd1;
                skp_pending <= skp_pending | ((sym_cnt_r + 16'd1) == SYM_MAX);
            end else begin
                sym_cnt_r   <= sym_cnt_r;
                skp_pending <= skp_pending;
            end

            if (accept_s) begin
                in_pkt_r <= !in_last;
            end

            case (state_r)
                ST_DATA: begin
                    if (go_s) begin
                        txdata  <= K_COM;
                        txdatak <= 1'b1;
                        state_r <= ST_COM;
                    end else if (in_valid) begin
                        txdata  <= in_data;
                        txdatak <= in_datak;
                    end else begin
                        txdata  <= IDLE_SYM;
                        txdatak <= 1'b0;
                    end
                end
                ST_COM: begin
                    txdata    <= K_SKP;
                    txdatak   <= 1'b1;
                    skp_cnt_r <= 3'd1;
                    state_r   <= last_skp_s ? ST_DATA : ST_SKP;
                end
                ST_SKP: begin
                    txdata    <= K_SKP;
                    txdatak   <= 1'b1;
                    skp_cnt_r <= skp_cnt_r + 3'd1;
                    state_r   <= last_skp_s ? ST_DATA : ST_SKP;
                end
                default: begin
                    txdata  <= IDLE_SYM;
                    txdatak <= 1'b0;
                    state_r <= ST_DATA;
                end
            endcase
        end
    end

`ifdef TX_SKP_STATS_EN
    // Completed-set counter; an aborted set never reaches its last SKP and is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            skp_sent_cnt <= 16'd0;
        end else if (last_skp_s) begin
            skp_sent_cnt <= skp_sent_cnt + 16'd1;
        end else begin
            skp_sent_cnt <= skp_sent_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_tx_skp_inserter.sv
// Randomized bench for tx_skp_inserter against a cycle-accounting reference model.
module tb_tx_skp_inserter;

    localparam int         I    = 16;
    localparam int         L    = 3;
    localparam logic [7:0] IDLE = 8'h00;
    localparam logic [8:0] SYM_COM = 9'h1BC;
    localparam logic [8:0] SYM_SKP = 9'h11C;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] in_data  = 8'h00;
    logic       in_datak = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last  = 1'b0;
    logic       in_ready;
    logic [7:0] txdata;
    logic       txdatak;
    logic       skp_pending;
`ifdef TX_SKP_STATS_EN
    logic [15:0] skp_sent_cnt;
`endif

    tx_skp_inserter #(.SKP_INTERVAL(I), .SKP_LEN(L), .IDLE_SYM(IDLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_datak    (in_datak),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .txdata      (txdata),
        .txdatak     (txdatak),
        .skp_pending (skp_pending)
`ifdef TX_SKP_STATS_EN
        ,
        .skp_sent_cnt(skp_sent_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         ref_cyc   = 0;    // cycle at which "symbols since COM/reset" was zero
    int         set_end   = -1;   // last cycle of the current set's in_ready=0 window
    bit         m_in_pkt  = 1'b0;
    bit         known     = 1'b0;
    bit         acc       = 1'b0;
    logic [8:0] exp_out   = 9'h000;
    int         exp_stats = 0;
    logic [7:0] seq       = 8'h00;
    int         pkt_len   = 1;
    int         pkt_pos   = 0;
    int         last_com  = -1;
    int         last_done = -1;
    bit         idle_chk  = 1'b0;
    bit         defer_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Offer a new symbol if none is outstanding; packets are numbered bytes with random K flags.
    task automatic drive(input int vpct, input int lmin, input int lmax);
        if (!in_valid && ($urandom_range(99) < vpct)) begin
            if (pkt_pos == 0) pkt_len = $urandom_range(lmax, lmin);
            in_valid = 1'b1;
            in_data  = seq;
            in_datak = ($urandom_range(7) == 0);
            in_last  = (pkt_pos == pkt_len - 1);
        end
    endtask

    // One clock: check the DUT at the falling edge, advance the model, move past the rising edge.
    task automatic step();
        bit in_set, pend, go, rdy;
        @(negedge clk);
        in_set = (cyc <= set_end);
        pend   = !in_set && ((cyc - ref_cyc) >= I - 1);
        go     = !reset && !in_set && pend && !m_in_pkt;
        rdy    = !reset && !in_set && !go;
        check("in_ready", in_ready, rdy);
        if (known) begin
            check("txsym", {txdatak, txdata}, exp_out);
            check("skp_pending", skp_pending, pend);
`ifdef TX_SKP_STATS_EN
            check("skp_sent_cnt", skp_sent_cnt, exp_stats);
`endif
            if ({txdatak, txdata} === SYM_COM) begin
                if (idle_chk && last_com >= 0) check("com_spacing", cyc - last_com, I);
                if (defer_chk) begin
                    check("com_after_last", cyc - last_done, 2);
                    defer_chk = 1'b0;
                end
                last_com = cyc;
            end
        end
        acc = in_valid && rdy;
        if (reset) begin
            exp_out   = 9'h000;
            ref_cyc   = cyc + 1;
            set_end   = -1;
            m_in_pkt  = 1'b0;
            exp_stats = 0;
            known     = 1'b1;
        end else begin
            if (go)            exp_out = SYM_COM;
            else if (in_set)   exp_out = SYM_SKP;
            else if (in_valid) exp_out = {in_datak, in_data};
            else               exp_out = {1'b0, IDLE};
            if (in_set && cyc == set_end) exp_stats = (exp_stats + 1) % 65536;
            if (go) begin
                ref_cyc = cyc + 1;
                set_end = cyc + L;
            end
            if (acc) m_in_pkt = !in_last;
        end
        if (acc && in_last) last_done = cyc;
        @(posedge clk);
        cyc++;
        #1;
        if (acc) begin
            seq      = seq + 8'd1;
            pkt_pos  = in_last ? 0 : pkt_pos + 1;
            in_valid = 1'b0;
        end
    endtask

    task automatic run(input int n, input int vpct, input int lmin, input int lmax);
        repeat (n) begin
            drive(vpct, lmin, lmax);
            step();
        end
    endtask

    task automatic finish_pkt(input int lmin, input int lmax);
        int b = 0;
        while ((in_valid || pkt_pos != 0) && b < 400) begin
            if (pkt_pos != 0) drive(100, lmin, lmax);
            step();
            b++;
        end
        if (b >= 400) check("finish_pkt_timeout", 1, 0);
    endtask

    initial begin
        int b;
        // Reset held for several cycles with a symbol offered; it must not be taken.
        pkt_len  = 4;
        in_valid = 1'b1;
        in_data  = seq;
        in_last  = 1'b0;
        repeat (4) step();
        reset = 1'b0;

        // Back-to-back 4-symbol packets.
        run(60, 100, 4, 4);
        finish_pkt(4, 4);

        // Idle only: COMs exactly I apart.
        idle_chk = 1'b1;
        last_com = -1;
        run(70, 0, 1, 1);
        idle_chk = 1'b0;

        // 40-symbol packet starting 2 cycles before pending sets.
        b = 0;
        while (!(cyc > set_end && (cyc - ref_cyc) == I - 3) && b < 100) begin step(); b++; end
        if (b >= 100) check("align_defer_timeout", 1, 0);
        defer_chk = 1'b1;
        drive(100, 40, 40);
        finish_pkt(40, 40);
        run(10, 0, 1, 1);
        if (defer_chk) check("defer_com_seen", 0, 1);
        defer_chk = 1'b0;

        // Mid-packet gap of 5 cycles while pending.
        b = 0;
        while (!(cyc > set_end && (cyc - ref_cyc) == I - 6) && b < 100) begin step(); b++; end
        if (b >= 100) check("align_gap_timeout", 1, 0);
        drive(100, 20, 20);
        b = 0;
        while (pkt_pos < 8 && b < 50) begin
            step();
            if (pkt_pos < 8) drive(100, 20, 20);
            b++;
        end
        repeat (5) begin
            step();
            check("gap_idle", {txdatak, txdata}, {1'b0, IDLE});
            check("gap_pending", skp_pending, 1);
        end
        finish_pkt(20, 20);
        run(10, 0, 1, 1);

        // Reset during the second SKP of a set.
        b = 0;
        while (!(set_end >= 0 && cyc == set_end - L + 3) && b < 100) begin step(); b++; end
        if (b >= 100) check("align_reset_timeout", 1, 0);
        reset = 1'b1;
        step();
        check("rst_txsym", {txdatak, txdata}, 9'h000);
`ifdef TX_SKP_STATS_EN
        check("rst_stats", skp_sent_cnt, 0);
`endif
        reset    = 1'b0;
        idle_chk = 1'b1;
        last_com = cyc;
        run(40, 0, 1, 1);
        idle_chk = 1'b0;

        // Random traffic with gaps and mixed packet lengths.
        run(1500, 70, 1, 12);
        finish_pkt(1, 12);
        run(20, 0, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
